// File: rtl/pipe_hazard_if.sv
// Pipeline hazard handshake bundle: ID/EX hazard sources and data-memory status
// in, stage-register enables and NOP-insert flushes out.
interface pipe_hazard_if;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       use_rs1_id;
  logic       use_rs2_id;
  logic [4:0] rd_ex;
  logic       mem_read_ex;
  logic       mispredict_ex;
  logic       dmem_ready;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex,
           mispredict_ex, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex,
           mispredict_ex, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, redirect flush, memory-wait
// freeze with sticky timeout. Define PIPE_HAZARD_PERF_EN to build the perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_hazard_if.slave hz,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t     state_q;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       pend_redir;
  logic       load_use;
  logic       redir_take;
  logic [4:0] en;
  logic       if_id_flush_c;
  logic       id_ex_flush_c;

  always_comb begin
    load_use = hz.mem_read_ex && (hz.rd_ex != 5'd0) &&
               ((hz.use_rs1_id && (hz.rs1_id == hz.rd_ex)) ||
                (hz.use_rs2_id && (hz.rs2_id == hz.rd_ex)));
  end

  // Mealy control: everything defaults to a full freeze, which also covers rst
  // and dmem_ready=0 in every state.
  always_comb begin
    en            = '0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    redir_take    = 1'b0;
    wait_nxt      = 8'd1;
    if (state_q == ST_WAIT)
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 8'd1;
    if (!rst && hz.dmem_ready) begin
      case (state_q)
        ST_REDIR: begin
          en            = '1;
          if_id_flush_c = 1'b1;
        end
        ST_RUN, ST_WAIT: begin
          if (hz.mispredict_ex || (state_q == ST_WAIT && pend_redir)) begin
            redir_take    = 1'b1;
            en            = '1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (load_use) begin
            en            = 5'b00111;
            id_ex_flush_c = 1'b1;
          end else begin
            en = '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.pc_en       = en[4];
  assign hz.if_id_en    = en[3];
  assign hz.id_ex_en    = en[2];
  assign hz.ex_mem_en   = en[1];
  assign hz.mem_wb_en   = en[0];
  assign hz.if_id_flush = if_id_flush_c;
  assign hz.id_ex_flush = id_ex_flush_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt    <= '0;
      pend_redir  <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (!hz.dmem_ready) begin
      state_q  <= ST_WAIT;
      wait_cnt <= wait_nxt;
      if (wait_nxt == WAIT_MAX)
        mem_timeout <= 1'b1;
      // A redirect interrupted by a freeze is owed once memory releases.
      if ((state_q == ST_WAIT && hz.mispredict_ex) || state_q == ST_REDIR)
        pend_redir <= 1'b1;
    end else begin
      state_q    <= redir_take ? ST_REDIR : ST_RUN;
      wait_cnt   <= '0;
      pend_redir <= 1'b0;
    end
  end

  assign state = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en[4])
        stall_q <= stall_q + 32'd1;
      if (redir_take)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// checked against a cycle-level behavioural model of the pipeline-control rules.
module tb_pipe_hazard_ctrl;
  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(.MAX_WAIT(MW)) dut (
    .clk         (clk),
    .rst         (rst),
    .hz          (hz),
    .state       (state),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: history of frozen cycles, an owed redirect, and whether this cycle is
  // the single squash slot after an accepted redirect.
  bit          m_prev_frozen = 1'b0;
  bit          m_redir_slot  = 1'b0;
  bit          m_owed        = 1'b0;
  int          m_frozen_run  = 0;
  bit          m_timeout     = 1'b0;
  logic [31:0] m_stall       = '0;
  logic [31:0] m_flush       = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_load_use();
    if (!hz.mem_read_ex || hz.rd_ex == 5'd0) return 1'b0;
    return (hz.use_rs1_id && hz.rs1_id == hz.rd_ex) ||
           (hz.use_rs2_id && hz.rs2_id == hz.rd_ex);
  endfunction

  function automatic bit m_mispredict();
    return hz.mispredict_ex || (m_prev_frozen && m_owed);
  endfunction

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  function automatic logic [6:0] m_ctl();
    if (rst || !hz.dmem_ready) return 7'b00000_00;
    if (m_redir_slot)          return 7'b11111_10;
    if (m_mispredict())        return 7'b11111_11;
    if (m_load_use())          return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_prev_frozen) return 2'd1;
    if (m_redir_slot)  return 2'd2;
    return 2'd0;
  endfunction

  task automatic m_advance();
    if (rst) begin
      m_prev_frozen = 0; m_redir_slot = 0; m_owed = 0;
      m_frozen_run = 0; m_timeout = 0; m_stall = '0; m_flush = '0;
    end else if (!hz.dmem_ready) begin
      if ((m_prev_frozen && hz.mispredict_ex) || m_redir_slot) m_owed = 1;
      m_frozen_run++;
      if (m_frozen_run >= int'(MW)) m_timeout = 1;
      m_stall++;
      m_prev_frozen = 1;
      m_redir_slot  = 0;
    end else begin
      if (m_redir_slot) begin
        m_redir_slot = 0;
      end else if (m_mispredict()) begin
        m_flush++;
        m_redir_slot = 1;
      end else if (m_load_use()) begin
        m_stall++;
      end
      m_owed = 0; m_frozen_run = 0; m_prev_frozen = 0;
    end
  endtask

  task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] rd,
                      input bit ld, input bit mp, input bit rdy);
    logic [6:0] obs;
    @(negedge clk);
    rst = r;
    hz.rs1_id = rs1; hz.rs2_id = rs2; hz.use_rs1_id = u1; hz.use_rs2_id = u2;
    hz.rd_ex = rd; hz.mem_read_ex = ld; hz.mispredict_ex = mp; hz.dmem_ready = rdy;
    #1;
    obs = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
           hz.if_id_flush, hz.id_ex_flush};
    chk("ctl", 32'(obs), 32'(m_ctl()));
    @(posedge clk);
    m_advance();
    #1;
    chk("state", 32'(state), 32'(m_state()));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
`ifdef PIPE_HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
    chk("flush_cnt", flush_cnt, 32'd0);
`endif
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    rst = 1'b1;
    hz.rs1_id = '0; hz.rs2_id = '0; hz.use_rs1_id = 0; hz.use_rs2_id = 0;
    hz.rd_ex = '0; hz.mem_read_ex = 0; hz.mispredict_ex = 0; hz.dmem_ready = 1;

    // Reset: outputs held at zero while rst=1.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    idle(1'b1);

    // Load-use on rs1, then rs2, then a masked (unused) source, then rd_ex=0.
    step(1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    step(1'b0, 5'd3, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd12, 5'd3, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);

    // Mispredict pulse in RUN, then REDIR, then RUN.
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Memory busy 3 cycles with a mispredict on the 2nd; release owes the redirect.
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Freeze during REDIR still owes the squash; mispredict beats load-use.
    step(1'b0, 5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Six busy cycles: timeout after the 4th, sticky after release.
    repeat (6) idle(1'b0);
    repeat (3) idle(1'b1);
    step(1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);

    // Reset mid-WAIT with the timeout already set.
    repeat (5) idle(1'b0);
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Random traffic with small register indices so hazards collide often.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 2,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) >= 25);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
